// File: rtl/multicycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_pkg
//   Shared definitions for the multicycle RISC-V style control unit and the
//   datapath it steers: FSM state encodings, opcode constants, opcode classes
//   and the select encodings of the datapath muxes.
// -----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF     = 3'd0,
    ST_ID     = 3'd1,
    ST_EX     = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JAL,
    CL_JALR,
    CL_SYS,
    CL_ILLEGAL
  } op_class_t;

  // Major opcodes (instruction bits [6:0])
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  // ALU operand A select
  localparam logic       ASRC_PC  = 1'b0;
  localparam logic       ASRC_RS1 = 1'b1;

  // ALU operand B select
  localparam logic [1:0] BSRC_RS2  = 2'd0;
  localparam logic [1:0] BSRC_FOUR = 2'd1;
  localparam logic [1:0] BSRC_IMM  = 2'd2;

  // Next-PC select
  localparam logic [1:0] PCSRC_PLUS4  = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_ALU    = 2'd2;

  // Register-file write-back select
  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_opcode_class.sv
// -----------------------------------------------------------------------------
// opcode_class
//   Pure combinational classifier: maps the 7-bit major opcode onto the class
//   the control FSM branches on. Anything not recognised is CL_ILLEGAL.
//   opcode   : instruction bits [6:0]
//   op_class : decoded class
// -----------------------------------------------------------------------------
module opcode_class
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    case (opcode)
      OP_REG, OP_IMM, OP_LUI, OP_AUIPC: op_class = CL_ALU;
      OP_LOAD:                          op_class = CL_LOAD;
      OP_STORE:                         op_class = CL_STORE;
      OP_BRANCH:                        op_class = CL_BRANCH;
      OP_JAL:                           op_class = CL_JAL;
      OP_JALR:                          op_class = CL_JALR;
      OP_ECALL:                         op_class = CL_SYS;
      default:                          op_class = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Control FSM of a multicycle RV32-style core (IF/ID/EX/MEM/WB/HALTED).
//   Ports:
//     CLK, RSTn            clock, asynchronous active-low reset
//     OPCODE               IR opcode field, stable from ID onward
//     BCOND                branch-taken flag from the ALU (EX)
//     MEM_READY            memory finishes the current access this cycle
//     STATE                current FSM state
//     PC/IR/ALUOUT/RF_WREN register write enables
//     MEM_READ/MEM_WRITE   memory strobes, I_OR_D selects PC(0)/ALUout(1)
//     ALUSRCA/ALUSRCB      ALU operand selects
//     PC_SRC/WB_SEL        next-PC and write-back selects
//     HALT/ILLEGAL         halted, halted due to an unknown opcode
//     NUM_INST             retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [6:0]       OPCODE,
  input  logic             BCOND,
  input  logic             MEM_READY,
  output logic [2:0]       STATE,
  output logic             PC_WREN,
  output logic             IR_WREN,
  output logic             ALUOUT_WREN,
  output logic             RF_WREN,
  output logic             MEM_READ,
  output logic             MEM_WRITE,
  output logic             I_OR_D,
  output logic             ALUSRCA,
  output logic [1:0]       ALUSRCB,
  output logic [1:0]       PC_SRC,
  output logic [1:0]       WB_SEL,
  output logic             HALT,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] NUM_INST
);

  state_t           state, state_nxt;
  op_class_t        op_cls;
  logic             illegal_q, illegal_set;
  logic [CNT_W-1:0] num_inst_q;

  logic pc_wren, ir_wren, aluout_wren, rf_wren, mem_read, mem_write;

  opcode_class u_opcode_class (
    .opcode   (OPCODE),
    .op_class (op_cls)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= ST_IF;
      illegal_q  <= 1'b0;
      num_inst_q <= '0;
    end else begin
      state <= state_nxt;
      if (illegal_set) illegal_q  <= 1'b1;
      // One PC write per retired instruction, so it doubles as the retire strobe.
      if (pc_wren)     num_inst_q <= num_inst_q + 1'b1;
    end
  end

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt   = state;
    illegal_set = 1'b0;
    pc_wren     = 1'b0;
    ir_wren     = 1'b0;
    aluout_wren = 1'b0;
    rf_wren     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    I_OR_D      = 1'b0;
    ALUSRCA     = ASRC_PC;
    ALUSRCB     = BSRC_FOUR;
    PC_SRC      = PCSRC_PLUS4;
    WB_SEL      = WB_ALUOUT;

    case (state)
      ST_IF: begin
        mem_read = 1'b1;
        if (MEM_READY) begin
          ir_wren   = 1'b1;
          state_nxt = ST_ID;
        end
      end

      ST_ID: begin
        // Branch/JAL target PC+imm is precomputed into ALUout here.
        ALUSRCA     = ASRC_PC;
        ALUSRCB     = BSRC_IMM;
        aluout_wren = 1'b1;
        case (op_cls)
          CL_SYS:     state_nxt = ST_HALTED;
          CL_ILLEGAL: begin
            state_nxt   = ST_HALTED;
            illegal_set = 1'b1;
          end
          default:    state_nxt = ST_EX;
        endcase
      end

      ST_EX: begin
        case (op_cls)
          CL_BRANCH: begin
            // ALU compares rs1/rs2; ALUout keeps the target from ID.
            ALUSRCA   = ASRC_RS1;
            ALUSRCB   = BSRC_RS2;
            pc_wren   = 1'b1;
            PC_SRC    = BCOND ? PCSRC_ALUOUT : PCSRC_PLUS4;
            state_nxt = ST_IF;
          end
          CL_LOAD, CL_STORE: begin
            ALUSRCA     = ASRC_RS1;
            ALUSRCB     = BSRC_IMM;
            aluout_wren = 1'b1;
            state_nxt   = ST_MEM;
          end
          CL_JAL: begin
            ALUSRCA     = ASRC_PC;
            ALUSRCB     = BSRC_IMM;
            aluout_wren = 1'b1;
            state_nxt   = ST_WB;
          end
          CL_JALR: begin
            ALUSRCA     = ASRC_RS1;
            ALUSRCB     = BSRC_IMM;
            aluout_wren = 1'b1;
            state_nxt   = ST_WB;
          end
          CL_ALU: begin
            ALUSRCA     = (OPCODE == OP_AUIPC) ? ASRC_PC : ASRC_RS1;
            ALUSRCB     = (OPCODE == OP_REG)   ? BSRC_RS2 : BSRC_IMM;
            aluout_wren = 1'b1;
            state_nxt   = ST_WB;
          end
          default: state_nxt = ST_HALTED;  // SYS/ILLEGAL never leave ID
        endcase
      end

      ST_MEM: begin
        I_OR_D = 1'b1;
        if (op_cls == CL_LOAD) mem_read  = 1'b1;
        else                   mem_write = 1'b1;
        if (MEM_READY) begin
          if (op_cls == CL_LOAD) begin
            state_nxt = ST_WB;
          end else begin
            pc_wren   = 1'b1;
            PC_SRC    = PCSRC_PLUS4;
            state_nxt = ST_IF;
          end
        end
      end

      ST_WB: begin
        rf_wren   = 1'b1;
        pc_wren   = 1'b1;
        state_nxt = ST_IF;
        case (op_cls)
          CL_LOAD:  WB_SEL = WB_MDR;
          CL_JAL:   begin
            WB_SEL = WB_PC4;
            PC_SRC = PCSRC_ALUOUT;
          end
          CL_JALR:  begin
            // JALR target rs1+imm comes straight off the ALU this cycle.
            WB_SEL  = WB_PC4;
            PC_SRC  = PCSRC_ALU;
            ALUSRCA = ASRC_RS1;
            ALUSRCB = BSRC_IMM;
          end
          default:  WB_SEL = WB_ALUOUT;
        endcase
      end

      ST_HALTED: state_nxt = ST_HALTED;

      default:   state_nxt = ST_IF;
    endcase
  end

  // Enables and strobes are masked by RSTn directly so nothing is written or
  // requested while reset is held, even though the state register sits in IF.
  assign PC_WREN     = pc_wren     & RSTn;
  assign IR_WREN     = ir_wren     & RSTn;
  assign ALUOUT_WREN = aluout_wren & RSTn;
  assign RF_WREN     = rf_wren     & RSTn;
  assign MEM_READ    = mem_read    & RSTn;
  assign MEM_WRITE   = mem_write   & RSTn;

  assign STATE    = state;
  assign HALT     = (state == ST_HALTED);
  assign ILLEGAL  = illegal_q;
  assign NUM_INST = num_inst_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on posedge CLK.
REQ-003 SHALL have port RSTn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port OPCODE  input  7  opcode field from the instruction register, stable from ID onward.
REQ-005 SHALL have port BCOND  input  1  branch-taken flag from the ALU, valid in EX.
REQ-006 SHALL have port MEM_READY  input  1  memory completes the current read/write this cycle.
REQ-007 SHALL have port STATE  output  3  current state encoding.
REQ-008 SHALL have ports PC_WREN, IR_WREN, ALUOUT_WREN, RF_WREN  output  1 each  write enables for PC, IR, ALUout and register-file registers.
REQ-009 SHALL have ports MEM_READ, MEM_WRITE, I_OR_D  output  1 each  memory strobes; I_OR_D 0=instruction address (PC), 1=data address (ALUout).
REQ-010 SHALL have ports ALUSRCA  output  1 (0=PC, 1=rs1), ALUSRCB  output  2 (0=rs2, 1=const 4, 2=imm).
REQ-011 SHALL have ports PC_SRC  output  2 (0=PC+4, 1=ALUout, 2=ALU result), WB_SEL  output  2 (0=ALUout, 1=MDR, 2=PC+4).
REQ-012 SHALL have ports HALT, ILLEGAL  output  1 each, and NUM_INST  output  CNT_W  retired-instruction count.

Function
REQ-013 SHALL implement states IF=0, ID=1, EX=2, MEM=3, WB=4, HALTED=5; outputs decoded from STATE, ready-qualified enables combinational with MEM_READY.
REQ-014 IF: MEM_READ=1, I_OR_D=0; stay in IF while MEM_READY=0; on MEM_READY=1 assert IR_WREN that cycle and go to ID.
REQ-015 ID: ALUSRCA=0, ALUSRCB=2, ALUOUT_WREN=1 (precompute PC+imm); ECALL 1110011 -> HALTED; unknown opcode -> HALTED with ILLEGAL=1; else -> EX.
REQ-016 EX: ALUOUT_WREN=1 except for BRANCH; R/I-ALU/LUI/AUIPC/JAL/JALR -> WB; LOAD/STORE -> MEM; BRANCH -> IF.
REQ-017 EX for BRANCH: PC_WREN=1, PC_SRC=1 if BCOND=1 else PC_SRC=0.
REQ-018 MEM: MEM_READ (LOAD) or MEM_WRITE (STORE), I_OR_D=1; hold while MEM_READY=0; on ready, LOAD -> WB, STORE -> IF with PC_WREN=1, PC_SRC=0.
REQ-019 WB: RF_WREN=1, PC_WREN=1; WB_SEL=1 for LOAD, 2 for JAL/JALR, else 0; PC_SRC=1 for JAL, 2 for JALR, else 0; -> IF.
REQ-020 PC_WREN SHALL assert exactly one cycle per retired instruction; NUM_INST increments in that cycle, wrapping from all-ones to 0.
REQ-021 HALTED SHALL be absorbing: HALT=1, all write enables and strobes 0, NUM_INST frozen.
REQ-022 MEM_READY asserted outside IF/MEM SHALL be ignored.

Reset
REQ-023 RSTn=0 SHALL force STATE=IF, NUM_INST=0, HALT=0, ILLEGAL=0 immediately, regardless of CLK.
REQ-024 While RSTn=0 all write enables and MEM_READ/MEM_WRITE SHALL be 0; reset mid-instruction aborts without further writes.
REQ-025 First IF fetch SHALL start on the first posedge after RSTn deasserts.

Structure
REQ-026 State encodings, opcode constants and mux-select encodings SHALL live in a shared package used by the datapath.
REQ-027 One sub-module, opcode_class, SHALL map OPCODE to class (ALU, LOAD, STORE, BRANCH, JAL, JALR, SYS, ILLEGAL).

Verification
REQ-028 ADD 0x002081B3, MEM_READY always 1 -> states IF,ID,EX,WB; RF_WREN and PC_WREN in cycle 4; NUM_INST=1.
REQ-029 LW with MEM_READY low 3 cycles in MEM -> MEM held 4 cycles, WB_SEL=1 in WB, no write before ready.
REQ-030 BEQ with BCOND=1 then BCOND=0 -> PC_SRC=1 then 0, 3 cycles each, RF_WREN never asserted.
REQ-031 Opcode 0x7F -> HALTED after ID, ILLEGAL=1, no further PC_WREN for 20 cycles.
REQ-032 RSTn pulsed low mid-MEM of SW -> STATE=IF asynchronously, MEM_WRITE drops, NUM_INST=0.
REQ-033 NUM_INST preloaded near wrap (CNT_W=4, 15 retirements then 1 more) -> reads 0.
